// File: rtl/apb_i2c_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_i2c_tx_fifo                                                 |
// | Purpose  : PCLK-domain FIFO between the APB slave and the I2C core, with   |
// |            occupancy, full/empty and overflow/underflow error pulses.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module apb_i2c_tx_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              CLR,
  input  logic              WR_EN,
  input  logic [DATA_W-1:0] WR_DATA,
  input  logic              RD_EN,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_VALID,
  output logic              FULL,
  output logic              EMPTY,
  output logic [ADDR_W:0]   COUNT,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
);

  localparam logic [ADDR_W:0]   c_DEPTH   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  logic w_pop_ok;
  logic w_push_ok;
  logic w_overflow;
  logic w_underflow;

  assign FULL  = (r_count == c_DEPTH);
  assign EMPTY = (r_count == '0);
  assign COUNT = r_count;

  // A flush cycle swallows both requests, so no error flag can be raised then.
  assign w_pop_ok    = !CLR && RD_EN && !EMPTY;
  assign w_push_ok   = !CLR && WR_EN && (!FULL || w_pop_ok);
  assign w_overflow  = !CLR && WR_EN && !w_push_ok;
  assign w_underflow = !CLR && RD_EN && EMPTY;

  // Storage is deliberately left out of reset.
  always_ff @(posedge PCLK) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= WR_DATA;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      RD_DATA   <= '0;
      RD_VALID  <= 1'b0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else if (CLR) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      RD_VALID  <= 1'b0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      RD_VALID  <= w_pop_ok;
      OVERFLOW  <= w_overflow;
      UNDERFLOW <= w_underflow;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop_ok) begin
        RD_DATA  <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_i2c_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_apb_i2c_tx_fifo                                              |
// | Purpose  : Scoreboard bench for apb_i2c_tx_fifo.                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_apb_i2c_tx_fifo;

  localparam int c_DATA_W = 32;
  localparam int c_DEPTH  = 16;
  localparam int c_ADDR_W = 4;

  logic                PCLK;
  logic                PRESETn;
  logic                CLR;
  logic                WR_EN;
  logic [c_DATA_W-1:0] WR_DATA;
  logic                RD_EN;
  logic [c_DATA_W-1:0] RD_DATA;
  logic                RD_VALID;
  logic                FULL;
  logic                EMPTY;
  logic [c_ADDR_W:0]   COUNT;
  logic                OVERFLOW;
  logic                UNDERFLOW;

  apb_i2c_tx_fifo #(
    .DATA_W (c_DATA_W),
    .DEPTH  (c_DEPTH),
    .ADDR_W (c_ADDR_W)
  ) u_dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .CLR       (CLR),
    .WR_EN     (WR_EN),
    .WR_DATA   (WR_DATA),
    .RD_EN     (RD_EN),
    .RD_DATA   (RD_DATA),
    .RD_VALID  (RD_VALID),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .COUNT     (COUNT),
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_checks;
  int n_fails;
  logic [c_DATA_W-1:0] sb_q [$];
  logic [c_DATA_W-1:0] r_last_rd;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus; expected flags come from the queue occupancy.
  task automatic cycle(input logic wr, input logic [c_DATA_W-1:0] data,
                       input logic rd, input logic clr);
    bit pop_ok, push_ok, ovf, udf;
    int sz;
    logic [c_DATA_W-1:0] exp_rd;
    WR_EN = wr; WR_DATA = data; RD_EN = rd; CLR = clr;
    sz      = sb_q.size();
    pop_ok  = !clr && rd && (sz > 0);
    push_ok = !clr && wr && ((sz < c_DEPTH) || pop_ok);
    ovf     = !clr && wr && !push_ok;
    udf     = !clr && rd && (sz == 0);
    if (push_ok) sb_q.push_back(data);
    @(posedge PCLK);
    #1;
    WR_EN = 1'b0; RD_EN = 1'b0; CLR = 1'b0;
    if (clr) sb_q.delete();
    check_val("rd_valid", 64'(RD_VALID), 64'(pop_ok));
    if (pop_ok) begin
      exp_rd = sb_q.pop_front();
      r_last_rd = exp_rd;
    end
    check_val("rd_data", 64'(RD_DATA), 64'(r_last_rd));
    check_val("count", 64'(COUNT), 64'(sb_q.size()));
    check_val("full", 64'(FULL), 64'(sb_q.size() == c_DEPTH));
    check_val("empty", 64'(EMPTY), 64'(sb_q.size() == 0));
    check_val("overflow", 64'(OVERFLOW), 64'(ovf));
    check_val("underflow", 64'(UNDERFLOW), 64'(udf));
  endtask

  initial begin
    n_checks = 0; n_fails = 0; r_last_rd = '0;
    PRESETn = 1'b0; CLR = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0; WR_DATA = '0;
    #12;
    check_val("rst_count", 64'(COUNT), 64'd0);
    check_val("rst_empty", 64'(EMPTY), 64'd1);
    check_val("rst_full", 64'(FULL), 64'd0);
    check_val("rst_rd_data", 64'(RD_DATA), 64'd0);
    check_val("rst_flags", {61'd0, RD_VALID, OVERFLOW, UNDERFLOW}, 64'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;

    // Fill in order, then one rejected push.
    for (int i = 0; i < c_DEPTH; i++) cycle(1'b1, 32'hA5A50000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Push and pop together while full, then drain.
    cycle(1'b1, 32'h11110000, 1'b1, 1'b0);
    for (int i = 0; i < c_DEPTH; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Pop on empty, then simultaneous push+pop on empty.
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h22220000, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // 40 push/pop pairs to cross the pointer wrap.
    cycle(1'b1, 32'h33330000, 1'b0, 1'b0);
    for (int i = 1; i <= 40; i++) cycle(1'b1, 32'h33330000 + 32'(i), 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with five words held; requests in the flush cycle are ignored.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h44440000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h4444FFFF, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h55550000 + 32'(i), 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    WR_EN = 1'b1; WR_DATA = 32'h5555AAAA;
    #2;
    PRESETn = 1'b0;
    #1;
    check_val("mid_rst_count", 64'(COUNT), 64'd0);
    check_val("mid_rst_empty", 64'(EMPTY), 64'd1);
    check_val("mid_rst_full", 64'(FULL), 64'd0);
    check_val("mid_rst_rd_data", 64'(RD_DATA), 64'd0);
    WR_EN = 1'b0;
    sb_q.delete();
    r_last_rd = '0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    cycle(1'b1, 32'h12345678, 1'b0, 1'b0);
    cycle(1'b1, 32'h9ABCDEF0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
